// File: rtl/gfp8_to_fp16.sv
// Converts one group-floating-point value (32-bit mantissa, 8-bit exponent) to IEEE binary16.
// Rounding is truncation by default; define GFP8_FP16_RNE_EN to get round-to-nearest-even.
module gfp8_to_fp16 #(
  parameter bit OVF_SATURATE = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_gfp_mantissa,
  input  logic [7:0]  i_gfp_exponent,
  input  logic        i_valid,
  output logic [15:0] o_fp16_result,
  output logic        o_valid
);

  localparam logic [14:0] OVF_WORD = OVF_SATURATE ? 15'h7BFF : 15'h7C00;

  // Index of the highest set bit; 0 for an all-zero input.
  function automatic logic [4:0] lead_one(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      idx = v[i] ? i[4:0] : idx;
    end
    return idx;
  endfunction

  logic              sign_s;
  logic [31:0]       mag_s;
  logic [4:0]        lead_s;
  logic [31:0]       norm_s;
  logic signed [9:0] exp_unb_s;
  logic signed [9:0] exp_bias_s;
  logic signed [9:0] sub_shift_s;
  logic [5:0]        sub_sh_s;
  logic [63:0]       sub_ext_s;
  logic [14:0]       packed_s;
  logic [14:0]       rounded_s;
  logic              guard_s;
  logic              sticky_s;
  logic              round_up_s;
  logic              ovf_s;
  logic [15:0]       result_s;
  logic              unused_s;

  // Normalise the magnitude and derive the unbiased/biased exponents.
  always_comb begin
    sign_s      = i_gfp_mantissa[31];
    mag_s       = sign_s ? (32'd0 - i_gfp_mantissa) : i_gfp_mantissa;
    lead_s      = lead_one(mag_s);
    norm_s      = mag_s << (5'd31 - lead_s);
    exp_unb_s   = {{2{i_gfp_exponent[7]}}, i_gfp_exponent} + {5'd0, lead_s};
    exp_bias_s  = exp_unb_s + 10'sd15;
    // Subnormal fraction = norm >> (7 - E); anything past 63 is pure sticky.
    sub_shift_s = 10'sd7 - exp_unb_s;
    if (sub_shift_s > 10'sd63) begin
      sub_sh_s = 6'd63;
    end else begin
      sub_sh_s = sub_shift_s[5:0];
    end
    sub_ext_s   = {norm_s, 32'd0} >> sub_sh_s;
  end

  // Select the pre-round exponent/fraction word and the discarded-bit summary.
  always_comb begin
    packed_s = 15'd0;
    guard_s  = 1'b0;
    sticky_s = 1'b0;
    ovf_s    = 1'b0;
    if (exp_bias_s > 10'sd30) begin
      ovf_s = 1'b1;
    end else if (exp_bias_s > 10'sd0) begin
      packed_s = {exp_bias_s[4:0], norm_s[30:21]};
      guard_s  = norm_s[20];
      sticky_s = |norm_s[19:0];
    end else begin
      packed_s = {5'd0, sub_ext_s[41:32]};
      guard_s  = sub_ext_s[31];
      sticky_s = |sub_ext_s[30:0];
    end
  end

  // Rounding increment; carry into the exponent field falls out of the add.
  always_comb begin
`ifdef GFP8_FP16_RNE_EN
    round_up_s = guard_s & (sticky_s | packed_s[0]);
`else
    round_up_s = 1'b0;
`endif
    rounded_s = packed_s + {14'd0, round_up_s};
  end

  // Final result: zero, overflow policy, or the rounded value with its sign.
  always_comb begin
    result_s = 16'h0000;
    if (mag_s == 32'd0) begin
      result_s = 16'h0000;
    end else if (ovf_s || (rounded_s[14:10] == 5'h1F)) begin
      result_s = {sign_s, OVF_WORD};
    end else begin
      result_s = {sign_s, rounded_s};
    end
  end

  assign unused_s = ^{sub_ext_s[63:42], norm_s[31], guard_s, sticky_s};

  // Single output register stage; result holds when no qualified input arrives.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fp16_result <= 16'h0000;
      o_valid       <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_fp16_result <= result_s;
      end else begin
        o_fp16_result <= o_fp16_result;
      end
    end
  end

endmodule

// File: tb/tb_gfp8_to_fp16.sv
// Directed scoreboard bench for gfp8_to_fp16; expectations follow GFP8_FP16_RNE_EN and OVF_SAT.
module tb_gfp8_to_fp16;

  localparam bit OVF_SAT = 1'b0;
`ifdef GFP8_FP16_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  localparam logic [15:0] INF_P = OVF_SAT ? 16'h7BFF : 16'h7C00;
  localparam logic [15:0] INF_N = OVF_SAT ? 16'hFBFF : 16'hFC00;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mant;
  logic [7:0]  expo;
  logic        vin;
  logic [15:0] res;
  logic        vout;

  int          total = 0;
  int          bad = 0;
  int          step = 0;
  logic [15:0] last_res = 16'h0000;
  logic [15:0] exp_q[$];
  int          tag_q[$];
  logic [15:0] stream_exp[8];

  always #5 clk = ~clk;

  gfp8_to_fp16 #(.OVF_SATURATE(OVF_SAT)) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_gfp_mantissa (mant),
    .i_gfp_exponent (expo),
    .i_valid        (vin),
    .o_fp16_result  (res),
    .o_valid        (vout)
  );

  // Output monitor: o_valid must mirror the input sampled at this edge; results pop the scoreboard.
  always @(posedge clk) begin
    logic [15:0] e;
    int          t;
    #1;
    if (reset_n === 1'b1) begin
      total++;
      assert (vout === vin) else begin
        bad++;
        $error("FAIL valid_latency observed=%b expected=%b", vout, vin);
      end
      if (vout === 1'b1) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_result observed=%h expected=none", res);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          total++;
          assert (res === e) else begin
            bad++;
            $error("FAIL step%0d observed=%h expected=%h", t, res, e);
          end
          last_res = e;
        end
      end else begin
        total++;
        assert (res === last_res) else begin
          bad++;
          $error("FAIL hold observed=%h expected=%h", res, last_res);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] m, input int e, input logic [15:0] x);
    mant = m;
    expo = e[7:0];
    vin  = 1'b1;
    exp_q.push_back(x);
    tag_q.push_back(step);
    step++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    vin  = 1'b0;
    mant = $urandom;
    expo = 8'($urandom);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    vin     = 1'b0;
    mant    = 32'd0;
    expo    = 8'd0;
    stream_exp = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                   16'h4500, 16'h4600, 16'h4700, 16'h4800};
    #12;
    total++;
    assert ({res, vout} === 17'h0_0000) else begin
      bad++;
      $error("FAIL reset_state observed=%h/%b expected=0000/0", res, vout);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic values with idle gaps between them
    drive(32'd1, 0, 16'h3C00);              idle(1);
    drive(-32'sd3, -1, 16'hBE00);           idle(2);
    drive(32'h8000_0000, -31, 16'hBC00);    idle(1);
    drive(32'd0, 17, 16'h0000);             idle(1);

    // Rounding, overflow, subnormal and boundary cases back to back
    drive(32'd2051, 0, RNE ? 16'h6802 : 16'h6801);
    drive(32'd65520, 0, RNE ? INF_P : 16'h7BFF);
    drive(32'd1, 16, INF_P);
    drive(32'hFFFF_FFFF, 16, INF_N);
    drive(32'd1, -24, 16'h0001);
    drive(32'd1, -15, 16'h0200);
    drive(32'd1, -26, 16'h0000);
    drive(-32'sd3, -25, RNE ? 16'h8002 : 16'h8001);
    drive(32'hFFFF_FFFF, -30, 16'h8000);
    drive(32'd0, 127, 16'h0000);
    drive(32'd1, 15, 16'h7800);
    drive(32'h8000_0000, -16, 16'hF800);
    drive(32'h8000_0000, -15, INF_N);
    drive(32'd1, -128, 16'h0000);
    drive(32'h7FFF_FFFF, 127, INF_P);
    drive(32'd2047, -25, RNE ? 16'h0400 : 16'h03FF);
    drive(32'h7FFF_FFFF, -16, RNE ? 16'h7800 : 16'h77FF);
    drive(32'd1, -10, 16'h1400);
    idle(2);

    // Eight-deep back-to-back stream, then a gap, then more
    for (int k = 0; k < 8; k++) begin
      drive(32'(k + 1), 0, stream_exp[k]);
    end
    idle(3);
    drive(32'd6, 0, 16'h4600);
    drive(32'd2, 0, 16'h4000);

    // Asynchronous reset in the middle of a live stream
    drive(32'd5, 0, 16'h4500);
    vin = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    assert ({res, vout} === 17'h0_0000) else begin
      bad++;
      $error("FAIL async_reset observed=%h/%b expected=0000/0", res, vout);
    end
    exp_q.delete();
    tag_q.delete();
    last_res = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    drive(-32'sd3, -1, 16'hBE00);
    drive(32'd7, 0, 16'h4700);
    idle(3);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL drain observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gfp8_to_fp16.md
GFP8_TO_FP16 -- requirements
Module: gfp8_to_fp16

Interface
REQ-001 Parameter OVF_SATURATE, default 0, overflow policy: 0 = produce ±infinity, 1 = produce ±max finite.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 i_gfp_mantissa  input  32  signed two's-complement group mantissa.
REQ-005 i_gfp_exponent  input  8  signed two's-complement exponent; input value = mantissa × 2^exponent.
REQ-006 i_valid  input  1  input qualifier.
REQ-007 o_fp16_result  output  16  IEEE 754 binary16 result, [15] sign, [14:10] biased exponent, [9:0] fraction.
REQ-008 o_valid  output  1  result qualifier.

Function
REQ-009 Latency SHALL be exactly 1 cycle: inputs sampled with i_valid=1 at edge N give o_valid=1 and the result after edge N.
REQ-010 o_valid SHALL be i_valid registered; no backpressure, and a new input SHALL be accepted every cycle.
REQ-011 With i_valid=0, o_valid SHALL be 0 and o_fp16_result SHALL hold its previous value.
REQ-012 Sign SHALL be mantissa[31]; magnitude SHALL be |mantissa| computed in 32 bits unsigned, so -2^31 gives magnitude 2^31.
REQ-013 Mantissa 0 SHALL produce 0x0000 for any exponent; negative zero is never produced.
REQ-014 Normalization: p = index of the leading one of the magnitude (0..31); unbiased exponent E = exponent + p (range -128..158, at least 9-bit signed arithmetic); biased Eb = E + 15.
REQ-015 Normal case, 1 ≤ Eb ≤ 30: fraction SHALL be the 10 bits below the leading one, rounded per REQ-021. Bits absent because p < 10 SHALL be zero-filled.
REQ-016 Subnormal case, Eb ≤ 0: result SHALL be magnitude × 2^(exponent+24) as a 10-bit fraction with exponent field 0, rounded per REQ-021. Values below the half-ulp threshold SHALL round to ±0 (sign kept).
REQ-017 Rounding carry SHALL propagate: a fraction overflow increments the exponent field, and a subnormal rounding up to 0x400 becomes the smallest normal.
REQ-018 Overflow, Eb ≥ 31 before or after rounding: result SHALL be sign|0x7C00 when OVF_SATURATE=0, or sign|0x7BFF when OVF_SATURATE=1.
REQ-019 NaN SHALL never be produced.
REQ-020 The datapath SHALL be combinational from inputs to a single output register stage.

Reset
REQ-022 Asynchronous assertion of i_reset_n=0 SHALL force o_fp16_result=0x0000 and o_valid=0 immediately, including in the middle of a stream.
REQ-023 The first conversion after deassertion SHALL behave per REQ-009, and no stale result SHALL appear.

Configuration
REQ-021 With macro GFP8_FP16_RNE_EN defined, rounding SHALL be round-to-nearest, ties-to-even, using guard and sticky bits over all discarded magnitude bits. Without the macro, rounding SHALL truncate toward zero (discarded bits dropped), so the overflow of REQ-018 can then only come from the pre-round exponent.

Verification
REQ-024 Basic values: (1,0) -> 0x3C00; (-3,-1) -> 0xBE00; (-2147483648,-31) -> 0xBC00; (0,17) -> 0x0000; each with o_valid high exactly one cycle after i_valid.
REQ-025 Rounding: (2051,0) -> 0x6802 with GFP8_FP16_RNE_EN, 0x6801 without it. (65520,0) -> 0x7C00 with RNE and OVF_SATURATE=0, 0x7BFF without RNE.
REQ-026 Overflow: (1,16) -> 0x7C00 (OVF_SATURATE=0) or 0x7BFF (OVF_SATURATE=1). (-1,16) -> 0xFC00 (OVF_SATURATE=0).
REQ-027 Subnormal: (1,-24) -> 0x0001; (1,-15) -> 0x0200; (1,-26) -> 0x0000; (-3,-25) -> 0x8002 with RNE, 0x8001 without.
REQ-028 Streaming/reset: back-to-back i_valid for 8 cycles gives 8 consecutive in-order results. An i_valid gap gives an o_valid gap with o_fp16_result held. Asserting i_reset_n=0 mid-stream clears both outputs asynchronously.
